// File: rtl/pcu_pkg.sv
// Shared types and constants for the program-counter unit.
package pcu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FETCH = 2'd2,
        EXEC  = 2'd3
    } pcu_state_e;

    localparam int unsigned INST_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pcu_watchdog.sv
// Fetch watchdog: counts enabled cycles and flags expiry on the TIMEOUT_CYCLES-th one.
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module pcu_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned LIMIT_M1 = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CW-1:0] LIMIT_M1_C = LIMIT_M1[CW-1:0];

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          expire_s;

    // Expiry and next count value
    always_comb begin
        expire_s = 1'b0;
        cnt_d    = cnt_q;
        if (TIMEOUT_CYCLES != 0) begin
            expire_s = en && (cnt_q == LIMIT_M1_C);
        end else begin
            expire_s = 1'b0;
        end
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else if (en && (TIMEOUT_CYCLES != 0)) begin
            cnt_d = expire_s ? {CW{1'b0}} : (cnt_q + CW'(1));
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = expire_s;

endmodule

// File: rtl/pcu.sv
// Program-counter unit: one instruction in flight, IDLE->REQ->FETCH->EXEC->REQ loop.
// Optional macro PCU_MISALIGN_CHK_EN redirects misaligned next-PCs to mtvec.
module pcu
    import pcu_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 64
) (
    input  logic             clock,
    input  logic             reset,
    output logic             pc_ready,
    output logic [31:0]      pc_out,
    input  logic             inst_valid,
    input  logic             wb_valid,
    input  logic             jump_en,
    input  logic [31:0]      jump_target,
    input  logic             trap_en,
    input  logic [31:0]      mtvec,
    input  logic             mret_en,
    input  logic [31:0]      mepc,
    output logic [31:0]      cur_pc,
    output logic [CNT_W-1:0] instret,
    output logic             fetch_timeout,
    output logic             misalign_trap,
    output logic [31:0]      misalign_addr
);

    pcu_state_e       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             pc_ready_q, pc_ready_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             fetch_timeout_q, fetch_timeout_d;
    logic             misalign_trap_q, misalign_trap_d;
    logic [31:0]      misalign_addr_q, misalign_addr_d;

    logic [31:0]      sel_pc_s;
    logic [31:0]      next_pc_s;
    logic             misalign_s;
    logic             wd_clr_s;
    logic             wd_en_s;
    logic             wd_expire_s;

    pcu_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clr    (wd_clr_s),
        .en     (wd_en_s),
        .expire (wd_expire_s)
    );

    // Redirect priority: trap, then mret, then jump, then sequential
    always_comb begin
        sel_pc_s = pc_q + 32'(INST_BYTES);
        if (trap_en) begin
            sel_pc_s = mtvec;
        end else if (mret_en) begin
            sel_pc_s = mepc;
        end else if (jump_en) begin
            sel_pc_s = jump_target;
        end else begin
            sel_pc_s = pc_q + 32'(INST_BYTES);
        end
    end

    // Misalignment screen on the selected target
    always_comb begin
        next_pc_s  = sel_pc_s;
        misalign_s = 1'b0;
`ifdef PCU_MISALIGN_CHK_EN
        if (is_misaligned(sel_pc_s)) begin
            next_pc_s  = mtvec;
            misalign_s = 1'b1;
        end else begin
            next_pc_s  = sel_pc_s;
            misalign_s = 1'b0;
        end
`else
        next_pc_s  = sel_pc_s;
        misalign_s = 1'b0;
`endif
    end

    // FSM next-state and output logic
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pc_ready_d      = 1'b0;
        instret_d       = instret_q;
        fetch_timeout_d = fetch_timeout_q;
        misalign_trap_d = 1'b0;
        misalign_addr_d = misalign_addr_q;
        wd_clr_s        = 1'b0;
        wd_en_s         = 1'b0;
        case (state_q)
            IDLE: begin
                state_d    = REQ;
                pc_ready_d = 1'b1;
            end
            REQ: begin
                wd_clr_s = 1'b1;
                state_d  = FETCH;
            end
            FETCH: begin
                wd_en_s = 1'b1;
                // A delivery in the expiry cycle takes precedence over the timeout
                if (inst_valid) begin
                    state_d = EXEC;
                end else if (wd_expire_s) begin
                    state_d         = REQ;
                    pc_ready_d      = 1'b1;
                    fetch_timeout_d = 1'b1;
                end else begin
                    state_d = FETCH;
                end
            end
            EXEC: begin
                if (wb_valid) begin
                    state_d         = REQ;
                    pc_ready_d      = 1'b1;
                    pc_d            = next_pc_s;
                    instret_d       = instret_q + CNT_W'(1);
                    misalign_trap_d = misalign_s;
                    if (misalign_s) begin
                        misalign_addr_d = sel_pc_s;
                    end else begin
                        misalign_addr_d = misalign_addr_q;
                    end
                end else begin
                    state_d = EXEC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            pc_q            <= RESET_PC;
            pc_ready_q      <= 1'b0;
            instret_q       <= {CNT_W{1'b0}};
            fetch_timeout_q <= 1'b0;
            misalign_trap_q <= 1'b0;
            misalign_addr_q <= 32'h0000_0000;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            pc_ready_q      <= pc_ready_d;
            instret_q       <= instret_d;
            fetch_timeout_q <= fetch_timeout_d;
            misalign_trap_q <= misalign_trap_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign pc_ready      = pc_ready_q;
    assign pc_out        = pc_q;
    assign cur_pc        = pc_q;
    assign instret       = instret_q;
    assign fetch_timeout = fetch_timeout_q;
    assign misalign_trap = misalign_trap_q;
    assign misalign_addr = misalign_addr_q;

endmodule
